// File: rtl/conv_ctrl_pkg.sv
// Shared types and sizing helpers for the conv loop-nest sequencer.
// The maxima here size the latched configuration record.
package conv_ctrl_pkg;

  localparam int FMAP_W_MAX = 128;
  localparam int FMAP_H_MAX = 128;
  localparam int STRIDE_MAX = 2;

  // Unsigned coordinate width able to hold the larger of the two map dimensions.
  function automatic int coord_width(input int w, input int h);
    return $clog2(((w > h) ? w : h) + 1);
  endfunction

  localparam int COORD_W = coord_width(FMAP_W_MAX, FMAP_H_MAX);
  localparam int CFG_W_W = $clog2(FMAP_W_MAX + 1);
  localparam int CFG_H_W = $clog2(FMAP_H_MAX + 1);
  localparam int CFG_S_W = $clog2(STRIDE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [CFG_W_W-1:0] width;
    logic [CFG_H_W-1:0] height;
    logic [CFG_S_W-1:0] stride;
  } cfg_t;

endpackage

// File: rtl/conv_loop_ctrl_if.sv
// Step handshake bus from the loop-nest sequencer to the PE datapath and
// address logic; the sequencer is the master.
interface conv_loop_ctrl_if
  import conv_ctrl_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = FMAP_W_MAX,
  parameter int FEATURE_MAP_HEIGHT = FMAP_H_MAX,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3
) ();

  localparam int CW    = coord_width(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT);
  localparam int OCH_W = $clog2(OUTPUT_NB_CHANNELS);
  localparam int ICH_W = $clog2(INPUT_NB_CHANNELS);
  localparam int K_W   = $clog2(KERNEL_SIZE);

  logic                    step_valid;
  logic                    step_ready;
  logic [CW-1:0]           out_x;
  logic [CW-1:0]           out_y;
  logic [OCH_W-1:0]        out_ch;
  logic [ICH_W-1:0]        in_ch;
  logic signed [CW:0]      in_x;
  logic signed [CW:0]      in_y;
  logic [K_W-1:0]          kx;
  logic [K_W-1:0]          ky;
  logic                    acc_first;
  logic                    acc_last;
  logic                    pad;

  modport master (
    output step_valid, out_x, out_y, out_ch, in_ch, in_x, in_y,
           kx, ky, acc_first, acc_last, pad,
    input  step_ready
  );

  modport slave (
    input  step_valid, out_x, out_y, out_ch, in_ch, in_x, in_y,
           kx, ky, acc_first, acc_last, pad,
    output step_ready
  );

endinterface

// File: rtl/conv_loop_counter.sv
// One dimension of the loop nest: counts 0..bound and wraps to 0 when
// incremented at bound; wrap feeds the next-outer counter's inc_en.
module conv_loop_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         clear,
  input  logic         inc_en,
  input  logic [W-1:0] bound,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic at_bound;

  assign at_bound = (count == bound);
  assign wrap     = inc_en && at_bound;

  // NOTE: non-blocking updates let every counter in the chain see the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_in || clear) begin
      count <= '0;
    end else if (inc_en) begin
      count <= at_bound ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_loop_ctrl.sv
// Loop-nest sequencer for the conv accelerator: walks y, x, ch_out, ch_in,
// ky, kx and emits one MAC step per handshake. CONV_ZERO_PAD_EN selects
// same-size zero padding; otherwise valid-only convolution.
module conv_loop_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = FMAP_W_MAX,
  parameter int FEATURE_MAP_HEIGHT = FMAP_H_MAX,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3,
  parameter int MAX_STRIDE         = STRIDE_MAX
) (
  input  logic                                     clk,
  input  logic                                     rst_in,
  input  logic                                     start,
  input  logic [$clog2(FEATURE_MAP_WIDTH+1)-1:0]   cfg_width,
  input  logic [$clog2(FEATURE_MAP_HEIGHT+1)-1:0]  cfg_height,
  input  logic [$clog2(MAX_STRIDE+1)-1:0]          cfg_stride,
  output logic                                     running,
  output logic                                     done,
  output logic                                     cfg_err,
  conv_loop_ctrl_if.master                         step
);

  localparam int CW    = coord_width(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT);
  localparam int OCH_W = $clog2(OUTPUT_NB_CHANNELS);
  localparam int ICH_W = $clog2(INPUT_NB_CHANNELS);
  localparam int K_W   = $clog2(KERNEL_SIZE);

`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
  localparam int OFS    = KERNEL_SIZE / 2;
`else
  localparam bit PAD_EN = 1'b0;
  localparam int OFS    = 0;
`endif

  // Output extent minus one is (dim - SPAN_SUB) / stride.
  localparam int SPAN_SUB = PAD_EN ? 1 : KERNEL_SIZE;

  state_t state, state_next;
  cfg_t   cfg_q;

  logic          cfg_ok, start_ok, hs;
  logic [CW-1:0] x_last, y_last, x_last_d, y_last_d;
  int            stride_div, ix, iy;

  logic [K_W-1:0]   kx_cnt, ky_cnt;
  logic [ICH_W-1:0] ich_cnt;
  logic [OCH_W-1:0] och_cnt;
  logic [CW-1:0]    ox_cnt, oy_cnt;
  logic             kx_wrap, ky_wrap, ich_wrap, och_wrap, ox_wrap, oy_wrap;

  always_comb begin
    cfg_ok = (cfg_stride != '0) && (int'(cfg_stride) <= MAX_STRIDE)
          && (cfg_width  != '0) && (int'(cfg_width)  <= FEATURE_MAP_WIDTH)
          && (cfg_height != '0) && (int'(cfg_height) <= FEATURE_MAP_HEIGHT)
          && (PAD_EN || ((int'(cfg_width) >= KERNEL_SIZE)
                      && (int'(cfg_height) >= KERNEL_SIZE)));
  end

  assign start_ok = (state == IDLE) && start && cfg_ok;
  assign hs       = (state == RUN) && step.step_ready;

  // Loop bounds are derived from the live cfg inputs and captured with start.
  always_comb begin
    stride_div = (cfg_stride == '0) ? 1 : int'(cfg_stride);
    x_last_d   = CW'((int'(cfg_width)  - SPAN_SUB) / stride_div);
    y_last_d   = CW'((int'(cfg_height) - SPAN_SUB) / stride_div);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      cfg_q   <= '0;
      x_last  <= '0;
      y_last  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (start_ok) begin
        cfg_q.width  <= CFG_W_W'(cfg_width);
        cfg_q.height <= CFG_H_W'(cfg_height);
        cfg_q.stride <= CFG_S_W'(cfg_stride);
        x_last       <= x_last_d;
        y_last       <= y_last_d;
      end
    end
  end

  conv_loop_counter #(.W(K_W)) u_kx (
    .clk(clk), .rst_in(rst_in), .clear(start_ok), .inc_en(hs),
    .bound(K_W'(KERNEL_SIZE - 1)), .count(kx_cnt), .wrap(kx_wrap)
  );

  conv_loop_counter #(.W(K_W)) u_ky (
    .clk(clk), .rst_in(rst_in), .clear(start_ok), .inc_en(kx_wrap),
    .bound(K_W'(KERNEL_SIZE - 1)), .count(ky_cnt), .wrap(ky_wrap)
  );

  conv_loop_counter #(.W(ICH_W)) u_ich (
    .clk(clk), .rst_in(rst_in), .clear(start_ok), .inc_en(ky_wrap),
    .bound(ICH_W'(INPUT_NB_CHANNELS - 1)), .count(ich_cnt), .wrap(ich_wrap)
  );

  conv_loop_counter #(.W(OCH_W)) u_och (
    .clk(clk), .rst_in(rst_in), .clear(start_ok), .inc_en(ich_wrap),
    .bound(OCH_W'(OUTPUT_NB_CHANNELS - 1)), .count(och_cnt), .wrap(och_wrap)
  );

  conv_loop_counter #(.W(CW)) u_ox (
    .clk(clk), .rst_in(rst_in), .clear(start_ok), .inc_en(och_wrap),
    .bound(x_last), .count(ox_cnt), .wrap(ox_wrap)
  );

  conv_loop_counter #(.W(CW)) u_oy (
    .clk(clk), .rst_in(rst_in), .clear(start_ok), .inc_en(ox_wrap),
    .bound(y_last), .count(oy_cnt), .wrap(oy_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The outermost wrap coincides with the handshake of the final step.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (oy_wrap)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    running         = (state == RUN);
    done            = (state == DONE);
    step.step_valid = (state == RUN);
  end

  always_comb begin
    ix = int'(ox_cnt) * int'(cfg_q.stride) + int'(kx_cnt) - OFS;
    iy = int'(oy_cnt) * int'(cfg_q.stride) + int'(ky_cnt) - OFS;
  end

  // Step fields are forced to zero outside RUN so idle/reset outputs are clean.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    step.out_x     = '0;
    step.out_y     = '0;
    step.out_ch    = '0;
    step.in_ch     = '0;
    step.in_x      = '0;
    step.in_y      = '0;
    step.kx        = '0;
    step.ky        = '0;
    step.acc_first = 1'b0;
    step.acc_last  = 1'b0;
    step.pad       = 1'b0;
    if (state == RUN) begin
      step.out_x     = ox_cnt;
      step.out_y     = oy_cnt;
      step.out_ch    = och_cnt;
      step.in_ch     = ich_cnt;
      step.in_x      = ix[CW:0];
      step.in_y      = iy[CW:0];
      step.kx        = kx_cnt;
      step.ky        = ky_cnt;
      step.acc_first = (ich_cnt == '0) && (ky_cnt == '0) && (kx_cnt == '0);
      step.acc_last  = (ich_cnt == ICH_W'(INPUT_NB_CHANNELS - 1))
                    && (ky_cnt == K_W'(KERNEL_SIZE - 1))
                    && (kx_cnt == K_W'(KERNEL_SIZE - 1));
      step.pad       = PAD_EN && ((ix < 0) || (ix >= int'(cfg_q.width))
                                || (iy < 0) || (iy >= int'(cfg_q.height)));
    end
  end

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Self-checking bench for conv_loop_ctrl: configuration table, randomized
// layers against a loop-nest reference model, back-pressure, abort and restart.
module tb_conv_loop_ctrl;
  import conv_ctrl_pkg::*;

  localparam int FMW  = 128;
  localparam int FMH  = 128;
  localparam int CIN  = 2;
  localparam int COUT = 2;
  localparam int K    = 3;
  localparam int MAXS = 2;

`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
  localparam int OFS    = K / 2;
`else
  localparam bit PAD_EN = 1'b0;
  localparam int OFS    = 0;
`endif

  localparam int DIM_W = $clog2(FMW + 1);
  localparam int HT_W  = $clog2(FMH + 1);
  localparam int S_W   = $clog2(MAXS + 1);
  localparam int CW    = coord_width(FMW, FMH);
  localparam int OCH_W = $clog2(COUT);
  localparam int ICH_W = $clog2(CIN);
  localparam int K_W   = $clog2(K);

  typedef struct packed {
    logic               running;
    logic               done;
    logic               cfg_err;
    logic               valid;
    logic [CW-1:0]      out_x;
    logic [CW-1:0]      out_y;
    logic [OCH_W-1:0]   out_ch;
    logic [ICH_W-1:0]   in_ch;
    logic signed [CW:0] in_x;
    logic signed [CW:0] in_y;
    logic [K_W-1:0]     kx;
    logic [K_W-1:0]     ky;
    logic               acc_first;
    logic               acc_last;
    logic               pad;
  } obs_t;

  typedef struct {
    int w;
    int h;
    int s;
    bit ok;
    int steps;
    int mode;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_in;
  logic             start;
  logic [DIM_W-1:0] cfg_width;
  logic [HT_W-1:0]  cfg_height;
  logic [S_W-1:0]   cfg_stride;
  logic             running, done, cfg_err;

  int   vectors = 0;
  int   errors  = 0;
  obs_t exp_q[$];
  obs_t first_hs, last_hs;
  vec_t vecs[10];

  conv_loop_ctrl_if #(
    .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
    .INPUT_NB_CHANNELS(CIN), .OUTPUT_NB_CHANNELS(COUT), .KERNEL_SIZE(K)
  ) step_bus ();

  conv_loop_ctrl #(
    .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
    .INPUT_NB_CHANNELS(CIN), .OUTPUT_NB_CHANNELS(COUT),
    .KERNEL_SIZE(K), .MAX_STRIDE(MAXS)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
    .running(running), .done(done), .cfg_err(cfg_err),
    .step(step_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.running   = running;
    o.done      = done;
    o.cfg_err   = cfg_err;
    o.valid     = step_bus.step_valid;
    o.out_x     = step_bus.out_x;
    o.out_y     = step_bus.out_y;
    o.out_ch    = step_bus.out_ch;
    o.in_ch     = step_bus.in_ch;
    o.in_x      = step_bus.in_x;
    o.in_y      = step_bus.in_y;
    o.kx        = step_bus.kx;
    o.ky        = step_bus.ky;
    o.acc_first = step_bus.acc_first;
    o.acc_last  = step_bus.acc_last;
    o.pad       = step_bus.pad;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    return o;
  endfunction

  function automatic obs_t done_obs();
    obs_t o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  function automatic obs_t err_obs();
    obs_t o = '0;
    o.cfg_err = 1'b1;
    return o;
  endfunction

  function automatic int out_dim(input int d, input int s);
    return PAD_EN ? (d - 1) / s + 1 : (d - K) / s + 1;
  endfunction

  function automatic bit cfg_valid(input int w, input int h, input int s);
    return (s >= 1) && (s <= MAXS) && (w > 0) && (h > 0) && (w <= FMW) && (h <= FMH)
        && (PAD_EN || ((w >= K) && (h >= K)));
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: the loop nest written out directly, one record per MAC step.
  task automatic build_model(input int w, input int h, input int s);
    obs_t o;
    int   ix, iy;
    exp_q.delete();
    for (int y = 0; y < out_dim(h, s); y++)
      for (int x = 0; x < out_dim(w, s); x++)
        for (int oc = 0; oc < COUT; oc++)
          for (int ic = 0; ic < CIN; ic++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++) begin
                ix = x * s + kx - OFS;
                iy = y * s + ky - OFS;
                o           = '0;
                o.running   = 1'b1;
                o.valid     = 1'b1;
                o.out_x     = CW'(x);
                o.out_y     = CW'(y);
                o.out_ch    = OCH_W'(oc);
                o.in_ch     = ICH_W'(ic);
                o.in_x      = (CW+1)'(ix);
                o.in_y      = (CW+1)'(iy);
                o.kx        = K_W'(kx);
                o.ky        = K_W'(ky);
                o.acc_first = (ic == 0) && (ky == 0) && (kx == 0);
                o.acc_last  = (ic == CIN - 1) && (ky == K - 1) && (kx == K - 1);
                o.pad       = PAD_EN && ((ix < 0) || (ix >= w) || (iy < 0) || (iy >= h));
                exp_q.push_back(o);
              end
  endtask

  // mode 0: always ready, 1: ready toggles, 2: random ready plus stray starts.
  task automatic run_layer(input int w, input int h, input int s, input bit ok,
                           input int steps, input int mode, input int abort_at);
    obs_t o;
    int   hs, cyc, budget, err0;
    bit   fin;
    if (ok) build_model(w, h, s);
    else    exp_q.delete();
    @(negedge clk);
    cfg_width          = DIM_W'(w);
    cfg_height         = HT_W'(h);
    cfg_stride         = S_W'(s);
    start              = 1'b1;
    step_bus.step_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!ok) begin
      check("reject_err", sample(), err_obs());
      @(negedge clk);
      check("reject_idle", sample(), idle_obs());
      return;
    end
    hs = 0; cyc = 0; fin = 1'b0; err0 = errors;
    budget = 4 * exp_q.size() + 64;
    while (!fin && (cyc < budget) && (errors - err0 <= 4)) begin
      if ((abort_at > 0) && (hs == abort_at)) begin
        start  = 1'b0;
        rst_in = 1'b1;
        @(negedge clk);
        check("abort_reset", sample(), idle_obs());
        rst_in = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("abort_no_done", sample(), idle_obs());
        end
        return;
      end
      case (mode)
        0:       step_bus.step_ready = 1'b1;
        1:       step_bus.step_ready = ~step_bus.step_ready;
        default: step_bus.step_ready = 1'($urandom_range(0, 1));
      endcase
      o = sample();
      if (exp_q.size() == 0) begin
        check("done_pulse", o, done_obs());
        fin   = 1'b1;
        start = 1'b0;
      end else begin
        check("step", o, exp_q[0]);
        if (step_bus.step_ready) begin
          if (hs == 0) first_hs = o;
          last_hs = o;
          void'(exp_q.pop_front());
          hs++;
        end
        if (mode == 2) begin
          start      = ($urandom_range(0, 3) == 0);
          cfg_width  = '0;
          cfg_stride = '0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) check_int("done_seen", 0, 1);
    check_int("step_count", hs, steps);
    if (fin) check("idle_after_done", sample(), idle_obs());
  endtask

  initial begin
    int w, h, s;
    bit ok;

`ifdef CONV_ZERO_PAD_EN
    vecs[0] = '{4, 4, 1, 1'b1, 576, 0};
    vecs[1] = '{5, 5, 2, 1'b1, 324, 2};
    vecs[2] = '{4, 4, 1, 1'b1, 576, 1};
    vecs[3] = '{2, 4, 1, 1'b1, 288, 0};
    vecs[8] = '{5, 4, 1, 1'b1, 720, 2};
    vecs[9] = '{3, 3, 2, 1'b1, 144, 0};
`else
    vecs[0] = '{4, 4, 1, 1'b1, 144, 0};
    vecs[1] = '{5, 5, 2, 1'b1, 144, 2};
    vecs[2] = '{4, 4, 1, 1'b1, 144, 1};
    vecs[3] = '{2, 4, 1, 1'b0, 0, 0};
    vecs[8] = '{5, 4, 1, 1'b1, 216, 2};
    vecs[9] = '{3, 3, 2, 1'b1, 36, 0};
`endif
    vecs[4] = '{4, 4, 0, 1'b0, 0, 0};
    vecs[5] = '{4, 4, 3, 1'b0, 0, 0};
    vecs[6] = '{0, 4, 1, 1'b0, 0, 0};
    vecs[7] = '{4, 129, 1, 1'b0, 0, 0};

    rst_in              = 1'b1;
    start               = 1'b0;
    cfg_width           = '0;
    cfg_height          = '0;
    cfg_stride          = '0;
    step_bus.step_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", sample(), idle_obs());
    rst_in = 1'b0;
    @(negedge clk);
    check("idle_after_reset", sample(), idle_obs());

    for (int i = 0; i < 10; i++) begin
      run_layer(vecs[i].w, vecs[i].h, vecs[i].s, vecs[i].ok, vecs[i].steps, vecs[i].mode, 0);
      if (i == 0) begin
        check_int("first_in_x", int'($signed(first_hs.in_x)), -OFS);
        check_int("first_pad", int'(first_hs.pad), int'(PAD_EN));
        check_int("first_acc_first", int'(first_hs.acc_first), 1);
      end
      if (i == 1) begin
        check_int("w5s2_last_in_x", int'($signed(last_hs.in_x)), PAD_EN ? 5 : 4);
        check_int("w5s2_last_in_y", int'($signed(last_hs.in_y)), PAD_EN ? 5 : 4);
        check_int("w5s2_last_acc_last", int'(last_hs.acc_last), 1);
      end
    end

    for (int i = 0; i < 3; i++) begin
      w  = $urandom_range(1, 9);
      h  = $urandom_range(1, 9);
      s  = $urandom_range(0, 3);
      ok = cfg_valid(w, h, s);
      run_layer(w, h, s, ok, ok ? out_dim(w, s) * out_dim(h, s) * COUT * CIN * K * K : 0, 2, 0);
    end

    run_layer(4, 4, 1, 1'b1, 0, 0, 50);
    run_layer(4, 4, 1, 1'b1, PAD_EN ? 576 : 144, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
